// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parity_pkg
// Description : Shared types and constants for the parity_stream block:
//               FSM state encoding and parity-mode selector values.
// Revision    : 1.0 - initial release
// ============================================================================
package parity_pkg;

    // Two-state packet FSM: accumulate beats, then hold the result.
    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Values for the ODD parameter of parity_stream.
    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

endpackage : parity_pkg
`default_nettype wire

// File: rtl/parity_reduce.sv
`default_nettype none
// ============================================================================
// Module      : parity_reduce
// Description : Combinational XOR reduction of one WIDTH-bit data word.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_reduce #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] data_i,
    output logic             parity_o
);

    logic [WIDTH-1:0] w_chain;

    // Ripple XOR chain; bit k holds the parity of data_i[k:0].
    assign w_chain[0] = data_i[0];

    generate
        for (genvar k = 1; k < WIDTH; k++) begin : g_xor
            assign w_chain[k] = w_chain[k-1] ^ data_i[k];
        end
    endgenerate

    assign parity_o = w_chain[WIDTH-1];

endmodule : parity_reduce
`default_nettype wire

// File: rtl/parity_stream.sv
`default_nettype none
// ============================================================================
// Module      : parity_stream
// Description : Accumulates parity over a ready/valid packet stream and
//               presents parity, saturating word count and an overflow flag
//               for each packet through a ready/valid result port.
//               Optional feature macro: PARITY_CHECK_EN (compares the
//               computed parity with parity_bit_in on the last beat).
// Revision    : 1.0 - initial release
// ============================================================================
module parity_stream
    import parity_pkg::*;
#(
    parameter int  WIDTH     = 4,
    parameter int  ODD       = 0,
    parameter int  MAX_WORDS = 16,
    localparam int CW        = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_last,
    input  logic             parity_bit_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             parity_out,
    output logic [CW-1:0]    word_count,
    output logic             overflow,
    output logic             parity_err
);

    localparam logic [CW-1:0] C_MAX = CW'(MAX_WORDS);
    localparam logic          C_ODD = (ODD == PARITY_ODD);

    state_t          state_q, state_d;
    logic            acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            par_q, par_d;
    logic [CW-1:0]   wc_q, wc_d;
    logic            ovo_q, ovo_d;

    logic            w_beat_par;
    logic            w_acc_new;
    logic            w_at_max;
    logic [CW-1:0]   w_cnt_new;
    logic            w_ovf_new;
    logic            w_par_res;

    parity_reduce #(
        .WIDTH (WIDTH)
    ) u_reduce (
        .data_i   (data_in),
        .parity_o (w_beat_par)
    );

    // Values that the current beat would produce if accepted.
    assign w_acc_new = acc_q ^ w_beat_par;
    assign w_at_max  = (cnt_q == C_MAX);
    assign w_cnt_new = w_at_max ? cnt_q : cnt_q + CW'(1);
    assign w_ovf_new = ovf_q | w_at_max;
    assign w_par_res = w_acc_new ^ C_ODD;

    // Handshake outputs decode directly from the state register.
    assign in_ready   = (state_q == ACC);
    assign out_valid  = (state_q == HOLD);
    assign parity_out = par_q;
    assign word_count = wc_q;
    assign overflow   = ovo_q;

    // Next-state logic: accumulate in ACC, capture on last beat, release on handshake.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        par_d   = par_q;
        wc_d    = wc_q;
        ovo_d   = ovo_q;
        case (state_q)
            ACC: begin
                if (in_valid) begin
                    acc_d = w_acc_new;
                    cnt_d = w_cnt_new;
                    ovf_d = w_ovf_new;
                    if (in_last) begin
                        par_d   = w_par_res;
                        wc_d    = w_cnt_new;
                        ovo_d   = w_ovf_new;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d   = 1'b0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    // State and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            par_q   <= 1'b0;
            wc_q    <= '0;
            ovo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            par_q   <= par_d;
            wc_q    <= wc_d;
            ovo_q   <= ovo_d;
        end
    end

`ifdef PARITY_CHECK_EN
    logic perr_q, perr_d;

    // Mismatch flag captured alongside the other results on the last beat.
    always_comb begin
        perr_d = perr_q;
        if ((state_q == ACC) && in_valid && in_last) begin
            perr_d = (w_par_res != parity_bit_in);
        end
    end

    // Mismatch flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    // Received parity has no function without the check feature.
    logic w_unused_pbit;
    assign w_unused_pbit = parity_bit_in;
    assign parity_err    = 1'b0;
`endif

endmodule : parity_stream
`default_nettype wire
